// File: rtl/hilo_pkg.sv
// Shared opcode encodings and sizing constants for the HI/LO unit.
package hilo_pkg;

  localparam int W_DEF        = 32;
  localparam int MULT_LAT_MAX = 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6
  } op_e;

endpackage

// File: rtl/hilo_pipe.sv
// Product delay line: DEPTH registered stages, each with its own valid bit.
// DEPTH==0 degenerates to a wire so the commit happens at the accept edge.
module hilo_pipe #(
  parameter int DW    = 64,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : g_stages
      logic [DW-1:0]    r_data [DEPTH];
      logic [DEPTH-1:0] r_valid;

      // Shift product and valid one stage per edge; reset drops anything in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= {DEPTH{1'b0}};
          for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= {DW{1'b0}};
          end
        end else begin
          r_valid[0] <= i_valid;
          r_data[0]  <= i_valid ? i_data : r_data[0];
          for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
          end
        end
      end

      assign o_valid = r_valid[DEPTH-1];
      assign o_data  = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: multiplier interface, product pipeline,
// move-to/move-from execution and the stall that keeps them ordered.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int W        = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_sign,
  input  logic [W-1:0] mul_hi,
  input  logic [W-1:0] mul_lo,
  output logic         stall,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic [W-1:0] hi_q,
  output logic [W-1:0] lo_q
);

  localparam int PW = $clog2(MULT_LAT + 1);

  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [PW-1:0]  r_pending;

  logic           w_is_mul;
  logic           w_is_mt;
  logic           w_is_mf;
  logic           w_sel_hi;
  logic           w_stall;
  logic           w_accept;
  logic           w_inc;
  logic           w_commit;
  logic [2*W-1:0] w_commit_data;
  logic           w_rd_valid;
  logic [W-1:0]   w_rd_data;

  // Opcode decode; unknown encodings fall through to no-op.
  always_comb begin
    w_is_mul = 1'b0;
    w_is_mt  = 1'b0;
    w_is_mf  = 1'b0;
    w_sel_hi = 1'b0;
    case (op_code)
      OP_MULT:  w_is_mul = 1'b1;
      OP_MULTU: w_is_mul = 1'b1;
      OP_MTHI:  begin w_is_mt = 1'b1; w_sel_hi = 1'b1; end
      OP_MTLO:  w_is_mt = 1'b1;
      OP_MFHI:  begin w_is_mf = 1'b1; w_sel_hi = 1'b1; end
      OP_MFLO:  w_is_mf = 1'b1;
      default:  w_is_mul = 1'b0;
    endcase
  end

  assign mul_a    = rs_data;
  assign mul_b    = rt_data;
  assign mul_sign = (op_code == OP_MULT);

  // Uses the registered count, so a read in the cycle of the final commit still waits.
  assign w_stall  = op_valid & (w_is_mf | w_is_mt) & (r_pending != {PW{1'b0}});
  assign w_accept = op_valid & ~w_stall;
  assign w_inc    = w_accept & w_is_mul;

  hilo_pipe #(
    .DW   (2*W),
    .DEPTH(MULT_LAT - 1)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(w_inc),
    .i_data ({mul_hi, mul_lo}),
    .o_valid(w_commit),
    .o_data (w_commit_data)
  );

  // Count of accepted multiplies whose product has not reached HI/LO yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= {PW{1'b0}};
    end else if (w_inc && !w_commit) begin
      r_pending <= r_pending + PW'(1);
    end else if (!w_inc && w_commit) begin
      r_pending <= r_pending - PW'(1);
    end else begin
      r_pending <= r_pending;
    end
  end

  // HI/LO update: pipeline commit or move-to (the two are mutually exclusive).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= {W{1'b0}};
      r_lo <= {W{1'b0}};
    end else if (w_commit) begin
      r_hi <= w_commit_data[2*W-1:W];
      r_lo <= w_commit_data[W-1:0];
    end else if (w_accept && w_is_mt) begin
      if (w_sel_hi) begin
        r_hi <= rs_data;
      end else begin
        r_lo <= rs_data;
      end
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Move-from read port; forced quiet while reset is asserted.
  always_comb begin
    w_rd_valid = rst_n & w_accept & w_is_mf;
    w_rd_data  = {W{1'b0}};
    if (w_rd_valid) begin
      w_rd_data = w_sel_hi ? r_hi : r_lo;
    end else begin
      w_rd_data = {W{1'b0}};
    end
  end

  assign stall    = w_stall;
  assign rd_valid = w_rd_valid;
  assign rd_data  = w_rd_data;
  assign hi_q     = r_hi;
  assign lo_q     = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed tables, hand sequences and
// random traffic against a queue-based model of in-flight products.
module tb_hilo_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
  logic [31:0] mul_a, mul_b, mul_hi, mul_lo, rd_data, hi_q, lo_q;
  logic        mul_sign, stall, rd_valid;

  logic        op_valid_4 = 1'b0;
  logic [2:0]  op_code_4 = 3'd0;
  logic [31:0] rs_data_4 = 32'd0, rt_data_4 = 32'd0;
  logic [31:0] mul_a_4, mul_b_4, mul_hi_4, mul_lo_4, rd_data_4, hi_q_4, lo_q_4;
  logic        mul_sign_4, stall_4, rd_valid_4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // External multiplier stand-ins
  assign {mul_hi, mul_lo}     = ref_mul(mul_a, mul_b, mul_sign);
  assign {mul_hi_4, mul_lo_4} = ref_mul(mul_a_4, mul_b_4, mul_sign_4);

  hilo_unit #(.MULT_LAT(LAT), .W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_hi(mul_hi), .mul_lo(mul_lo), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .hi_q(hi_q), .lo_q(lo_q)
  );

  hilo_unit #(.MULT_LAT(4), .W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid_4), .op_code(op_code_4),
    .rs_data(rs_data_4), .rt_data(rt_data_4), .mul_a(mul_a_4), .mul_b(mul_b_4),
    .mul_sign(mul_sign_4), .mul_hi(mul_hi_4), .mul_lo(mul_lo_4), .stall(stall_4),
    .rd_data(rd_data_4), .rd_valid(rd_valid_4), .hi_q(hi_q_4), .lo_q(lo_q_4)
  );

  // Reference model: architectural HI/LO plus a queue of products with edges left.
  typedef struct { logic [63:0] p; int cnt; } inflight_t;
  inflight_t   mq[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
  endfunction

  // One clock of the LAT=2 DUT: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic stalled, output logic sgn, output logic rdv, output logic [31:0] rd);
    logic is_mf, is_mt, is_mul, e_stall, e_rdv;
    logic [31:0] e_rd;
    logic [63:0] p;
    op_valid = v; op_code = op; rs_data = rs; rt_data = rt;
    @(negedge clk);
    is_mf   = v && (op == 3'd5 || op == 3'd6);
    is_mt   = v && (op == 3'd3 || op == 3'd4);
    is_mul  = v && (op == 3'd1 || op == 3'd2);
    e_stall = (is_mf || is_mt) && (mq.size() != 0);
    e_rdv   = is_mf && !e_stall;
    e_rd    = e_rdv ? ((op == 3'd5) ? m_hi : m_lo) : 32'd0;
    chk("stall", stall, e_stall);
    chk("mul_a", mul_a, rs);
    chk("mul_b", mul_b, rt);
    chk("mul_sign", mul_sign, op == 3'd1);
    chk("rd_valid", rd_valid, e_rdv);
    chk("rd_data", rd_data, e_rd);
    chk("hi_q", hi_q, m_hi);
    chk("lo_q", lo_q, m_lo);
    stalled = stall; sgn = mul_sign; rdv = rd_valid; rd = rd_data;
    @(posedge clk);
    foreach (mq[i]) mq[i].cnt = mq[i].cnt - 1;
    if (mq.size() != 0 && mq[0].cnt == 0) begin
      {m_hi, m_lo} = mq[0].p;
      void'(mq.pop_front());
    end
    if (is_mul) begin
      p = ref_mul(rs, rt, op == 3'd1);
      if (LAT == 1) {m_hi, m_lo} = p;
      else mq.push_back('{p: p, cnt: LAT - 1});
    end
    if (is_mt && !e_stall) begin
      if (op == 3'd3) m_hi = rs;
      else m_lo = rs;
    end
    #1;
  endtask

  // Present an op until accepted (bounded); report stall cycles and read result.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls, output logic sgn, output logic rdv, output logic [31:0] rd);
    logic st;
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, op, rs, rt, st, sgn, rdv, rd);
      if (!st) break;
      stalls++;
    end
    chk("issue_bound", stalls < 16, 1'b1);
  endtask

  task automatic idle(input int n);
    logic st, sg, rv;
    logic [31:0] rd;
    for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, st, sg, rv, rd);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        exp_sign;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          stalls;
    logic        sgn, rdv, st;
    logic [31:0] rd;

    tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    tbl[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[4] = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    // Reset state, with a read presented to prove outputs stay quiet
    op_valid = 1'b1; op_code = 3'd5;
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_lo", lo_q, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI then MFHI/MFLO with nothing in flight
    issue(3'd3, 32'h1234_5678, 32'd0, stalls, sgn, rdv, rd);
    chk("mthi_stalls", stalls, 0);
    issue(3'd5, 32'd0, 32'd0, stalls, sgn, rdv, rd);
    chk("mfhi_stalls", stalls, 0);
    chk("mfhi_valid", rdv, 1'b1);
    chk("mfhi_data", rd, 32'h1234_5678);
    issue(3'd6, 32'd0, 32'd0, stalls, sgn, rdv, rd);
    chk("mflo_stalls", stalls, 0);
    chk("mflo_data", rd, 32'd0);

    // Directed product table: sign select and HI/LO exactly LAT edges later
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].op, tbl[i].rs, tbl[i].rt, stalls, sgn, rdv, rd);
      chk("tbl_sign", sgn, tbl[i].exp_sign);
      chk("tbl_early_hi", hi_q != tbl[i].exp_hi || lo_q != tbl[i].exp_lo || LAT == 1, 1'b1);
      idle(LAT - 1);
      chk("tbl_hi", hi_q, tbl[i].exp_hi);
      chk("tbl_lo", lo_q, tbl[i].exp_lo);
    end

    // MULT followed immediately by MFHI: one stall, then the new HI
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, stalls, sgn, rdv, rd);
    issue(3'd5, 32'd0, 32'd0, stalls, sgn, rdv, rd);
    chk("mf_after_mult_stalls", stalls, 1);
    chk("mf_after_mult_data", rd, 32'hFFFF_FFFF);

    // Back-to-back MULTU then MFLO: last product wins
    issue(3'd2, 32'd3, 32'd5, stalls, sgn, rdv, rd);
    issue(3'd2, 32'd7, 32'd9, stalls, sgn, rdv, rd);
    chk("b2b_no_stall", stalls, 0);
    issue(3'd6, 32'd0, 32'd0, stalls, sgn, rdv, rd);
    chk("b2b_stalls", stalls, 1);
    chk("b2b_lo", rd, 32'h0000_003F);
    chk("b2b_hi", hi_q, 32'd0);

    // MTLO behind a multiply stalls too
    issue(3'd1, 32'd2, 32'd3, stalls, sgn, rdv, rd);
    issue(3'd4, 32'hABCD_0000, 32'd0, stalls, sgn, rdv, rd);
    chk("mt_stalls", stalls, 1);
    chk("mt_lo", lo_q, 32'hABCD_0000);
    chk("mt_hi_kept", hi_q, 32'd0);

    // Reset one cycle after a MULT accept discards the product
    issue(3'd2, 32'h0001_0000, 32'h0001_0000, stalls, sgn, rdv, rd);
    rst_n = 1'b0; op_valid = 1'b1; op_code = 3'd5;
    #2;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_hi", hi_q, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    idle(LAT + 1);
    chk("post_rst_hi", hi_q, 32'd0);
    chk("post_rst_lo", lo_q, 32'd0);
    issue(3'd5, 32'd0, 32'd0, stalls, sgn, rdv, rd);
    chk("post_rst_stalls", stalls, 0);
    chk("post_rst_rd", rd, 32'd0);
    chk("post_rst_rdv", rdv, 1'b1);

    // Random traffic (stalled ops are simply dropped, which the model tolerates)
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, st, sgn, rdv, rd);
    end
    idle(LAT + 1);
    op_valid = 1'b0;

    // MULT_LAT=4 instance: MFHI right after MULT stalls three cycles
    op_valid_4 = 1'b1; op_code_4 = 3'd1; rs_data_4 = 32'hFFFF_FFFF; rt_data_4 = 32'h0000_0002;
    @(negedge clk);
    chk("lat4_sign", mul_sign_4, 1'b1);
    chk("lat4_mult_stall", stall_4, 1'b0);
    @(posedge clk); #1;
    op_code_4 = 3'd5;
    stalls = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!stall_4) break;
      stalls++;
      @(posedge clk); #1;
    end
    chk("lat4_stalls", stalls, 3);
    chk("lat4_rd_valid", rd_valid_4, 1'b1);
    chk("lat4_rd_data", rd_data_4, 32'hFFFF_FFFF);
    chk("lat4_lo", lo_q_4, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    op_valid_4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
